// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- sequencer between the CPU and the external multiplier and
// divider units. It accepts one MULT/DIV request at a time and latches the
// operands. It strobes the selected unit and waits for that unit's done
// strobe, with a timeout. It then writes HI/LO, or raises a divide-by-zero
// or timeout exception pulse instead.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   req_valid, req_op               request strobe, 0 = MULT / 1 = DIV
//   rs_val, rt_val                  operands (rt_val is the divisor)
//   abort                           pipeline flush, cancels in-flight op
//   mult_done_in, div_done_in       unit completion strobes
//   mult_hi/lo, div_quot/rem        unit results, valid in the done cycle
//   req_ready, busy                 idle / stall indications
//   MultStart, DivStart             one-cycle unit start strobes
//   op_a, op_b                      latched operands to both units
//   HIWrite, LOWrite, hi_data, lo_data   HI/LO write port
//   div_zero_exc, timeout_exc       one-cycle exception pulses
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 48  // legal range 1..63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        abort,
    input  logic        mult_done_in,
    input  logic        div_done_in,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        req_ready,
    output logic        busy,
    output logic        MultStart,
    output logic        DivStart,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        HIWrite,
    output logic        LOWrite,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data,
    output logic        div_zero_exc,
    output logic        timeout_exc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_EXC   = 3'd4;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] CNT_MAX  = 6'd63;

    logic [2:0]  state_q, state_d;
    logic        op_q, op_d;          // 0 = MULT, 1 = DIV
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        dz_q, dz_d;          // EXC cause: 1 = divide-by-zero, 0 = timeout
    logic        sel_done;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        dz_d     = dz_q;
        // Only the unit we started may finish the operation.
        sel_done = op_q ? div_done_in : mult_done_in;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE has no state effect but still blocks acceptance.
                if (req_valid && !abort) begin
                    op_d   = req_op;
                    op_a_d = rs_val;
                    op_b_d = rt_val;
                    if (req_op && (rt_val == 32'd0)) begin
                        state_d = S_EXC;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_START;
                        dz_d    = 1'b0;
                    end
                end
            end
            S_START: begin
                cnt_d   = 6'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done in the final counted cycle beats the timeout.
                if (sel_done) begin
                    hi_d    = op_q ? div_rem  : mult_hi;
                    lo_d    = op_q ? div_quot : mult_lo;
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    dz_d    = 1'b0;
                    state_d = S_EXC;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            op_a_q  <= 32'd0;
            op_b_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 6'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    // Strobes come from registered state. The only combinational term is
    // the abort mask, which kills any side effect in the flush cycle.
    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign MultStart    = (state_q == S_START) && !op_q && !abort;
    assign DivStart     = (state_q == S_START) &&  op_q && !abort;
    assign HIWrite      = (state_q == S_WRITE) && !abort;
    assign LOWrite      = (state_q == S_WRITE) && !abort;
    assign div_zero_exc = (state_q == S_EXC) &&  dz_q && !abort;
    assign timeout_exc  = (state_q == S_EXC) && !dz_q && !abort;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign hi_data      = hi_q;
    assign lo_data      = lo_q;

endmodule
